// File: rtl/key_input_conditioner.sv
// key_input_conditioner: synchronise, debounce and edge-detect the 12 keypad keys.
// Ports:
//   CLK             system clock
//   global_safe_rst asynchronous active-high reset
//   key_raw         raw keys, active-high ([0]=KEY_1..[8]=KEY_9, [9]=STAR, [10]=KEY_0, [11]=SHARP)
//   key_level       debounced key state
//   key_press       one-cycle pulse after an armed debounced rise
//   key_release     one-cycle pulse after an armed debounced fall
//   key_hold        armed key held for HOLD_N strobes
//   key_repeat      auto-repeat pulses while key_hold is high
//   any_press       OR of key_press
module key_input_conditioner #(
  parameter int SAMPLE_DIV = 50000,
  parameter int DEBOUNCE_N = 8,
  parameter int HOLD_N     = 1000,
  parameter int REPEAT_N   = 100
) (
  input  logic        CLK,
  input  logic        global_safe_rst,
  input  logic [11:0] key_raw,
  output logic [11:0] key_level,
  output logic [11:0] key_press,
  output logic [11:0] key_release,
  output logic [11:0] key_hold,
  output logic [11:0] key_repeat,
  output logic        any_press
);
  localparam int PW = $clog2(SAMPLE_DIV);
  localparam int DW = $clog2(DEBOUNCE_N + 1);
  localparam int HW = $clog2(HOLD_N + 1);
  localparam int RW = $clog2(REPEAT_N + 1);
  logic [11:0]   s1, s2;
  logic [PW-1:0] pcnt;
  logic          strobe;
  assign strobe    = pcnt == PW'(SAMPLE_DIV - 1);
  assign any_press = |key_press;
  always_ff @(posedge CLK or posedge global_safe_rst)
    if (global_safe_rst) begin
      s1   <= '0;
      s2   <= '0;
      pcnt <= '0;
    end else begin
      s1   <= key_raw;
      s2   <= s1;
      pcnt <= strobe ? '0 : pcnt + 1'b1;
    end
  for (genvar g = 0; g < 12; g++) begin : gen_key
    logic [DW-1:0] cnt, cnt_n;
    logic [HW-1:0] hcnt;
    logic [RW-1:0] rcnt;
    logic          lvl, lvl_d, arm, press, rel, hold_d, wrap;
    always_comb
      cnt_n = !strobe ? cnt :
              s2[g]   ? (cnt < DW'(DEBOUNCE_N) ? cnt + 1'b1 : cnt) :
                        (cnt != '0 ? cnt - 1'b1 : cnt);
    assign key_level[g]   = lvl;
    assign key_press[g]   = press;
    assign key_release[g] = rel;
    // hold is gated by the live level so it drops in the same cycle the level falls
    assign key_hold[g]    = arm & lvl & (hcnt == HW'(HOLD_N));
    // first repeat rides on the hold rising edge, later ones on each counter wrap
    assign key_repeat[g]  = key_hold[g] & (~hold_d | wrap);
    always_ff @(posedge CLK or posedge global_safe_rst)
      if (global_safe_rst) begin
        cnt    <= '0;
        lvl    <= 1'b0;
        lvl_d  <= 1'b0;
        arm    <= 1'b0;
        press  <= 1'b0;
        rel    <= 1'b0;
        hcnt   <= '0;
        rcnt   <= '0;
        hold_d <= 1'b0;
        wrap   <= 1'b0;
      end else begin
        cnt    <= cnt_n;
        lvl    <= cnt_n == DW'(DEBOUNCE_N) ? 1'b1 : cnt_n == '0 ? 1'b0 : lvl;
        lvl_d  <= lvl;
        // arming also needs the synchronised input low, so a key held through
        // reset (level still 0 while the integrator climbs) cannot arm itself
        arm    <= arm | (strobe & ~lvl & ~s2[g]);
        press  <= lvl & ~lvl_d & arm;
        rel    <= ~lvl & lvl_d & arm;
        hcnt   <= !lvl ? '0 : (strobe & arm & hcnt != HW'(HOLD_N)) ? hcnt + 1'b1 : hcnt;
        hold_d <= key_hold[g];
        rcnt   <= !key_hold[g] ? '0 : !strobe ? rcnt : rcnt == RW'(REPEAT_N - 1) ? '0 : rcnt + 1'b1;
        wrap   <= key_hold[g] & strobe & (rcnt == RW'(REPEAT_N - 1));
      end
  end
endmodule

// File: tb/tb_key_input_conditioner.sv
// tb_key_input_conditioner: directed table plus corner sequences for key_input_conditioner.
module tb_key_input_conditioner;
  logic        CLK = 1'b0;
  logic        global_safe_rst = 1'b1;
  logic [11:0] key_raw = '0;
  logic [11:0] key_level, key_press, key_release, key_hold, key_repeat;
  logic        any_press;
  int total = 0, bad = 0;
  int npress, nrel, nrep, nany;
  logic [11:0] lvl_seen, hold_seen;
  typedef struct {
    logic [11:0] raw;
    int          on_cyc;
    int          half;
    int          exp_press;
    int          exp_rel;
    int          exp_rep;
    logic [11:0] exp_lvl;
    logic [11:0] exp_hold;
    int          exp_any;
  } vec_t;
  vec_t tv[6];
  key_input_conditioner #(.SAMPLE_DIV(4), .DEBOUNCE_N(3), .HOLD_N(10), .REPEAT_N(4)) dut (
    .CLK(CLK), .global_safe_rst(global_safe_rst), .key_raw(key_raw),
    .key_level(key_level), .key_press(key_press), .key_release(key_release),
    .key_hold(key_hold), .key_repeat(key_repeat), .any_press(any_press)
  );
  always #5 CLK = ~CLK;
  always @(negedge CLK) begin
    for (int i = 0; i < 12; i++) begin
      npress += int'(key_press[i]);
      nrel   += int'(key_release[i]);
      nrep   += int'(key_repeat[i]);
    end
    nany      += int'(any_press);
    lvl_seen  |= key_level;
    hold_seen |= key_hold;
  end
  task automatic step(input int n);
    repeat (n) begin
      @(posedge CLK);
      #1;
    end
  endtask
  task automatic clr();
    npress = 0; nrel = 0; nrep = 0; nany = 0; lvl_seen = '0; hold_seen = '0;
  endtask
  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask
  function automatic int all_out();
    return int'(|{key_level, key_press, key_release, key_hold, key_repeat, any_press});
  endfunction
  initial begin
    int t;
    int dt;
    logic prev_hold;
    clr();
    tv[0] = '{12'h400, 30, 0, 1, 1, 0, 12'h400, 12'h000, 1};
    tv[1] = '{12'h200, 40, 4, 0, 0, 0, 12'h000, 12'h000, 0};
    tv[2] = '{12'h008, 120, 0, 1, 1, 5, 12'h008, 12'h008, 1};
    tv[3] = '{12'h801, 30, 0, 2, 2, 0, 12'h801, 12'h000, 1};
    tv[4] = '{12'hfff, 30, 0, 12, 12, 0, 12'hfff, 12'h000, 1};
    tv[5] = '{12'h020, 6, 0, 0, 0, 0, 12'h000, 12'h000, 0};
    step(3);
    chk("reset_outputs_zero", all_out(), 0);
    global_safe_rst = 1'b0;
    step(30);
    chk("idle_outputs_zero", all_out(), 0);
    for (int r = 0; r < 6; r++) begin
      clr();
      for (int c = 0; c < tv[r].on_cyc; c++) begin
        key_raw = (tv[r].half == 0 || ((c / tv[r].half) % 2) == 0) ? tv[r].raw : 12'h000;
        step(1);
      end
      key_raw = '0;
      step(60);
      chk($sformatf("v%0d_press", r), npress, tv[r].exp_press);
      chk($sformatf("v%0d_release", r), nrel, tv[r].exp_rel);
      chk($sformatf("v%0d_repeat", r), nrep, tv[r].exp_rep);
      chk($sformatf("v%0d_level_seen", r), int'(lvl_seen), int'(tv[r].exp_lvl));
      chk($sformatf("v%0d_hold_seen", r), int'(hold_seen), int'(tv[r].exp_hold));
      chk($sformatf("v%0d_any_cycles", r), nany, tv[r].exp_any);
    end
    // KEY_0 latency and pulse widths
    key_raw = 12'h400;
    t = 0;
    while (!key_level[10] && t < 30) begin
      step(1);
      t++;
    end
    chk("k0_level_latency_ok", int'(t <= 18), 1);
    chk("k0_press_before_rise", int'(key_press[10]), 0);
    step(1);
    chk("k0_press_pulse", int'(key_press[10]), 1);
    step(1);
    chk("k0_press_one_cycle", int'(key_press[10]), 0);
    step(60 - t - 2);
    key_raw = '0;
    t = 0;
    while (key_level[10] && t < 30) begin
      step(1);
      t++;
    end
    chk("k0_level_fell", int'(key_level[10]), 0);
    step(1);
    chk("k0_release_pulse", int'(key_release[10]), 1);
    step(1);
    chk("k0_release_one_cycle", int'(key_release[10]), 0);
    step(30);
    // KEY_4 hold / repeat timing
    key_raw = 12'h008;
    t = 0;
    while (!key_level[3] && t < 30) begin
      step(1);
      t++;
    end
    dt = 0;
    while (!key_hold[3] && dt < 80) begin
      step(1);
      dt++;
    end
    chk("k4_hold_delay", dt, 40);
    chk("k4_first_repeat_with_hold", int'(key_repeat[3]), 1);
    step(1);
    dt = 1;
    while (!key_repeat[3] && dt < 40) begin
      step(1);
      dt++;
    end
    chk("k4_repeat_interval", dt, 16);
    step(10);
    key_raw = '0;
    prev_hold = key_hold[3];
    t = 0;
    while (key_level[3] && t < 30) begin
      prev_hold = key_hold[3];
      step(1);
      t++;
    end
    chk("k4_hold_before_fall", int'(prev_hold), 1);
    chk("k4_hold_drops_with_level", int'(key_hold[3]), 0);
    step(30);
    // keys 8 and STAR held through reset
    key_raw = 12'h280;
    step(30);
    #2 global_safe_rst = 1'b1;
    step(3);
    global_safe_rst = 1'b0;
    clr();
    step(60);
    chk("chord_level_seen", int'(lvl_seen), 12'h280);
    chk("chord_no_press", npress, 0);
    chk("chord_no_hold", int'(hold_seen), 0);
    key_raw = '0;
    step(60);
    chk("chord_no_release", nrel, 0);
    clr();
    key_raw = 12'h280;
    step(30);
    key_raw = '0;
    step(60);
    chk("chord_repress", npress, 2);
    chk("chord_repress_any", nany, 1);
    // asynchronous reset while KEY_5 is in hold
    key_raw = 12'h010;
    step(70);
    chk("k5_hold_active", int'(key_hold[4]), 1);
    #3 global_safe_rst = 1'b1;
    #1 chk("async_reset_clears", all_out(), 0);
    key_raw = '0;
    step(2);
    global_safe_rst = 1'b0;
    step(5);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
